mult_div_unit: RTL and testbench

//  Parametrised multicycle multiply/divide unit owning the HI/LO register pair of the MIPS datapath.

---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_step.sv | 36 +++
 rtl/mult_div_unit.sv | 147 ++++++++++++++
 tb/tb_mult_div_unit.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes and FSM states.
// The helpers decode the op field so that the top and the bench read it the same way.
package mdu_pkg;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIN  = 2'b10
  } mdu_state_e;

  localparam int MDU_MIN_WIDTH = 4;

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV);
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One radix-2 iteration on unsigned magnitudes: shift-add for multiply,
// restoring shift-subtract for divide. Purely combinational.
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] operand_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;
  logic             fits;

  always_comb begin
    // Multiply: {acc, q} holds the running product; the multiplier drains out of q's LSB.
    sum    = {1'b0, acc_i} + (q_i[0] ? {1'b0, operand_i} : '0);
    // Divide: the partial remainder can exceed WIDTH bits for one step, hence the extra bit.
    rem_sh = {acc_i, q_i[WIDTH-1]};
    fits   = (rem_sh >= {1'b0, operand_i});
    diff   = rem_sh[WIDTH-1:0] - operand_i;

    if (is_div_i) begin
      acc_o = fits ? diff : rem_sh[WIDTH-1:0];
      q_o   = {q_i[WIDTH-2:0], fits};
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multicycle multiply/divide unit owning HI/LO. Operands are reduced to magnitudes at
// start, iterated WIDTH times through mdu_step, then sign-corrected into HI/LO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  mdu_state_e       state_q;
  logic             div_q;
  logic             neg_q;
  logic             rem_neg_q;
  logic             busy_q;
  logic             done_q;
  logic             div_zero_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] opnd_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic [WIDTH-1:0]   acc_d;
  logic [WIDTH-1:0]   q_d;
  logic [WIDTH-1:0]   hi_d;
  logic [WIDTH-1:0]   lo_d;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH-1:0]   quot;
  logic [WIDTH-1:0]   rem;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic               op_signed;
  logic               op_div;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (div_q),
    .acc_i     (acc_q),
    .q_i       (q_q),
    .operand_i (opnd_q),
    .acc_o     (acc_d),
    .q_o       (q_d)
  );

  always_comb begin
    op_signed = is_signed_op(op);
    op_div    = is_div_op(op);
    // The MIN magnitude wraps back to MIN, which read unsigned is exactly 2^(WIDTH-1).
    a_mag     = (op_signed && a[WIDTH-1]) ? -a : a;
    b_mag     = (op_signed && b[WIDTH-1]) ? -b : b;

    // Final results are taken from the last step's outputs so HI/LO land with done.
    prod      = {acc_d, q_d};
    prod_fix  = neg_q ? -prod : prod;
    quot      = neg_q ? -q_d : q_d;
    rem       = rem_neg_q ? -acc_d : acc_d;
    hi_d      = div_q ? rem  : prod_fix[2*WIDTH-1:WIDTH];
    lo_d      = div_q ? quot : prod_fix[WIDTH-1:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      div_q      <= 1'b0;
      neg_q      <= 1'b0;
      rem_neg_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      cnt_q      <= '0;
      acc_q      <= '0;
      q_q        <= '0;
      opnd_q     <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
    end else begin
      done_q     <= 1'b0;
      div_zero_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            if (op_div && (b == '0)) begin
              state_q    <= FIN;
              done_q     <= 1'b1;
              div_zero_q <= 1'b1;
            end else begin
              state_q   <= RUN;
              busy_q    <= 1'b1;
              div_q     <= op_div;
              neg_q     <= op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
              rem_neg_q <= op_signed && op_div && a[WIDTH-1];
              cnt_q     <= CW'(WIDTH - 1);
              acc_q     <= '0;
              // Multiply shifts the multiplier out of q; divide shifts the dividend out of q.
              q_q       <= op_div ? a_mag : b_mag;
              opnd_q    <= op_div ? b_mag : a_mag;
            end
          end
        end
        RUN: begin
          acc_q <= acc_d;
          q_q   <= q_d;
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == '0) begin
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = div_zero_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit (WIDTH=32 instance plus a WIDTH=8 instance).
// Inputs change and outputs are sampled on the falling edge.
module tb_mult_div_unit;
  import mdu_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        hi_we;
  logic        lo_we;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  logic        start8;
  logic [1:0]  op8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        done8;
  logic        div_zero8;
  logic [7:0]  hi8;
  logic [7:0]  lo8;

  int errors = 0;
  int checks = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  mult_div_unit #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .a(a8), .b(b8),
    .hi_we(1'b0), .lo_we(1'b0), .wdata(8'h00),
    .busy(busy8), .done(done8), .div_zero(div_zero8), .hi(hi8), .lo(lo8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one operation; lat counts cycles after the accepting edge until done is seen.
  task automatic do_op(input logic [1:0] o, input logic [31:0] aa, input logic [31:0] bb,
                       output int lat, output int bcnt, output logic dz);
    @(negedge clk);
    op = o; a = aa; b = bb; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 1; bcnt = 0;
    while (!done && lat < 100) begin
      if (busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    dz = div_zero;
    if (!done) begin
      checks++; errors++;
      $display("FAIL op_timeout: done not seen within %0d cycles", lat);
    end
    $display("op=%0d a=%h b=%h -> lat=%0d busy_cycles=%0d hi=%h lo=%h dz=%0b",
             o, aa, bb, lat, bcnt, hi, lo, dz);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done_timeout: done not seen within %0d cycles", n);
    end
  endtask

  task automatic write_reg(input logic to_hi, input logic [31:0] v);
    @(negedge clk);
    hi_we = to_hi; lo_we = !to_hi; wdata = v;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    $display("write %s <= %h", to_hi ? "hi" : "lo", v);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if (hi !== 32'h0)    begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0)    begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
    checks++; if (busy !== 1'b0)   begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)   begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_div_zero: got %b want 0", div_zero); end
    $display("reset released: hi=%h lo=%h busy=%b done=%b", hi, lo, busy, done);
  endtask

  task automatic test_multu_max;
    int lat, bc; logic dz;
    do_op(MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, dz);
    checks++; if (lat != 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", lat); end
    checks++; if (bc != 32)  begin errors++; $display("FAIL multu_busy_cycles: got %0d want 32", bc); end
    checks++; if (hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
    checks++; if (lo !== 32'h00000001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL multu_dz: got %b want 0", dz); end
  endtask

  task automatic test_mult_signed;
    int lat, bc; logic dz;
    do_op(MDU_MULT, 32'hFFFFFFF9, 32'd3, lat, bc, dz);
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL mult_neg_hi: got %h want ffffffff", hi); end
    checks++; if (lo !== 32'hFFFFFFEB) begin errors++; $display("FAIL mult_neg_lo: got %h want ffffffeb", lo); end
    do_op(MDU_MULT, 32'h80000000, 32'h80000000, lat, bc, dz);
    checks++; if (hi !== 32'h40000000) begin errors++; $display("FAIL mult_min_hi: got %h want 40000000", hi); end
    checks++; if (lo !== 32'h00000000) begin errors++; $display("FAIL mult_min_lo: got %h want 00000000", lo); end
  endtask

  task automatic test_div_signed;
    int lat, bc; logic dz;
    do_op(MDU_DIV, 32'hFFFFFFF9, 32'd2, lat, bc, dz);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'hFFFFFFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
    checks++; if (lat != 33) begin errors++; $display("FAIL div_latency: got %0d want 33", lat); end
    do_op(MDU_DIV, 32'd7, 32'hFFFFFFFE, lat, bc, dz);
    checks++; if (lo !== 32'hFFFFFFFD) begin errors++; $display("FAIL div_negdivisor_lo: got %h want fffffffd", lo); end
    checks++; if (hi !== 32'h00000001) begin errors++; $display("FAIL div_negdivisor_hi: got %h want 00000001", hi); end
    do_op(MDU_DIV, 32'h80000000, 32'hFFFFFFFF, lat, bc, dz);
    checks++; if (lo !== 32'h80000000) begin errors++; $display("FAIL div_min_lo: got %h want 80000000", lo); end
    checks++; if (hi !== 32'h00000000) begin errors++; $display("FAIL div_min_hi: got %h want 00000000", hi); end
    checks++; if (dz !== 1'b0) begin errors++; $display("FAIL div_min_dz: got %b want 0", dz); end
  endtask

  task automatic test_div_zero;
    int lat, bc; logic dz;
    write_reg(1'b1, 32'hAAAA0000);
    write_reg(1'b0, 32'h0000BBBB);
    do_op(MDU_DIVU, 32'd100, 32'd0, lat, bc, dz);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
    checks++; if (dz !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", dz); end
    checks++; if (bc != 0) begin errors++; $display("FAIL dz_busy: got %0d busy cycles want 0", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_at_done: got %b want 0", busy); end
    checks++; if (hi !== 32'hAAAA0000) begin errors++; $display("FAIL dz_hi_kept: got %h want aaaa0000", hi); end
    checks++; if (lo !== 32'h0000BBBB) begin errors++; $display("FAIL dz_lo_kept: got %h want 0000bbbb", lo); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || div_zero !== 1'b0)
      begin errors++; $display("FAIL dz_pulse_width: got done=%b dz=%b want 0/0", done, div_zero); end
  endtask

  task automatic test_start_during_run;
    int lat; int dcnt;
    @(negedge clk);
    op = MDU_DIVU; a = 32'd17; b = 32'd5; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lat = 1;
    op = MDU_MULTU; a = 32'd9; b = 32'd9;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    dcnt = done ? 1 : 0;
    checks++; if (lat != 33) begin errors++; $display("FAIL restart_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL restart_lo: got %h want 3", lo); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL restart_hi: got %h want 2", hi); end
    repeat (5) begin
      @(negedge clk);
      if (done) dcnt++;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_no_second_op: busy=%b want 0", busy); end
    end
    checks++; if (dcnt != 1) begin errors++; $display("FAIL restart_done_count: got %0d want 1", dcnt); end
    $display("divu 17/5 with start held: lat=%0d done_count=%0d hi=%h lo=%h", lat, dcnt, hi, lo);
  endtask

  task automatic test_reset_mid_run;
    int lat, bc, dcnt; logic dz;
    @(negedge clk);
    op = MDU_MULT; a = 32'd5; b = 32'd6; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    #1;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midreset_hi: got %h want 0", hi); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midreset_lo: got %h want 0", lo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    @(negedge clk);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    checks++; if (dcnt != 0) begin errors++; $display("FAIL midreset_aborted: got %0d active cycles want 0", dcnt); end
    $display("reset mid-run: active cycles after reset=%0d", dcnt);
    do_op(MDU_MULTU, 32'd6, 32'd7, lat, bc, dz);
    checks++; if (lat != 33) begin errors++; $display("FAIL postreset_latency: got %0d want 33", lat); end
    checks++; if (lo !== 32'd42 || hi !== 32'd0)
      begin errors++; $display("FAIL postreset_result: got hi=%h lo=%h want 0/2a", hi, lo); end
  endtask

  task automatic test_mthi_mtlo;
    int n;
    write_reg(1'b1, 32'h00001234);
    write_reg(1'b0, 32'h00005678);
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678)
      begin errors++; $display("FAIL mt_idle: got hi=%h lo=%h want 1234/5678", hi, lo); end
    @(negedge clk);
    op = MDU_MULTU; a = 32'd2; b = 32'd3; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    hi_we = 1'b1; wdata = 32'hDEAD;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'hBEEF;
    @(negedge clk);
    lo_we = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mt_run_busy: got %b want 1", busy); end
    checks++; if (hi !== 32'h1234 || lo !== 32'h5678)
      begin errors++; $display("FAIL mt_run_ignored: got hi=%h lo=%h want 1234/5678", hi, lo); end
    wait_done(n);
    checks++; if (hi !== 32'd0 || lo !== 32'd6)
      begin errors++; $display("FAIL mt_run_result: got hi=%h lo=%h want 0/6", hi, lo); end
    $display("multu 2*3 with mthi/mtlo during run: hi=%h lo=%h", hi, lo);
    @(negedge clk);
    op = MDU_MULTU; a = 32'd4; b = 32'd5; start = 1'b1; hi_we = 1'b1; wdata = 32'h99;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0;
    checks++; if (hi !== 32'h99 || busy !== 1'b1)
      begin errors++; $display("FAIL mt_same_cycle: got hi=%h busy=%b want 99/1", hi, busy); end
    wait_done(n);
    checks++; if (hi !== 32'd0 || lo !== 32'd20)
      begin errors++; $display("FAIL mt_same_cycle_result: got hi=%h lo=%h want 0/14", hi, lo); end
    $display("multu 4*5 with same-cycle mthi: hi=%h lo=%h", hi, lo);
  endtask

  task automatic test_width8;
    int lat;
    @(negedge clk);
    op8 = MDU_DIVU; a8 = 8'd200; b8 = 8'd7; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 1;
    while (!done8 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    checks++; if (lat != 9) begin errors++; $display("FAIL w8_latency: got %0d want 9", lat); end
    checks++; if (lo8 !== 8'd28) begin errors++; $display("FAIL w8_lo: got %0d want 28", lo8); end
    checks++; if (hi8 !== 8'd4) begin errors++; $display("FAIL w8_hi: got %0d want 4", hi8); end
    $display("w8 divu 200/7: lat=%0d hi=%0d lo=%0d", lat, hi8, lo8);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
    hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
    start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
    test_reset();
    test_multu_max();
    test_mult_signed();
    test_div_signed();
    test_div_zero();
    test_start_during_run();
    test_reset_mid_run();
    test_mthi_mtlo();
    test_width8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
